// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: transmitter state encoding and the baud divider arithmetic.
// The receiver imports the same package so both sides agree on timing.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS = 8;

    function automatic int baud_divider(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // A divider of 1 still needs a one-bit counter to keep the vector legal.
    function automatic int baud_cnt_width(input int divider);
        return (divider > 1) ? $clog2(divider) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-queue port of the UART transmitter, plus status and a state debug view.
// Handshake: tx_start is valid, !tx_full is ready; a byte moves on a clk edge where both are high.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    tx_state_e  state;

    modport master (
        output tx_data, tx_start,
        input  tx_full, tx_empty, tx_busy, state
    );

    modport slave (
        input  tx_data, tx_start,
        output tx_full, tx_empty, tx_busy, state
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Count-based byte FIFO; rd_data_o is the head entry, valid while empty_o is low.
// Flags decode the registered count, so a push while full is refused even if a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push      = wr_en_i & ~full_o;
    assign pop       = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until the count says it was written.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed from a small byte FIFO.
// Back-to-back frames pop the next byte on the last stop cycle so no idle gap appears on the line.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus,
    output logic      tx
);

    localparam int DIVIDER = baud_divider(CLK_FREQ, BAUD_RATE);
    localparam int CW      = baud_cnt_width(DIVIDER);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDER - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          pop;
    logic [7:0]    head;
    logic          fifo_full, fifo_empty;
    logic          baud_last;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (bus.tx_start),
        .wr_data_i (bus.tx_data),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign baud_last = (cnt_q == CNT_LAST);

    // The line level is registered from the current state, so tx trails the state by one clk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d  = 1'b0;
                cnt_d = baud_last ? '0 : cnt_q + 1'b1;
                if (baud_last) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d  = shift_q[0];
                cnt_d = baud_last ? '0 : cnt_q + 1'b1;
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_d  = 1'b1;
                cnt_d = baud_last ? '0 : cnt_q + 1'b1;
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx           = tx_q;
    assign bus.tx_full  = fifo_full;
    assign bus.tx_empty = fifo_empty;
    assign bus.tx_busy  = (state_q != ST_IDLE) | ~fifo_empty;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 25 MHz / 115200 baud (217 clk per bit).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int D    = 217;
    localparam int HALF = 108;

    logic clk;
    logic rst_n;
    logic tx;
    int   checks;
    int   errors;

    uart_tx_if bus ();

    uart_tx #(
        .CLK_FREQ   (25000000),
        .BAUD_RATE  (115200),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.tx_data  = b;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
    endtask

    // Push into an idle, empty block: pop one clk later, line falls the clk after that.
    task automatic push_expect_fall(input logic [7:0] b, input string tag);
        push(b);
        check({tag, "_tx_pre"}, 32'(tx), 32'd1);
        check({tag, "_empty_pushed"}, 32'(bus.tx_empty), 32'd0);
        check({tag, "_busy_pushed"}, 32'(bus.tx_busy), 32'd1);
        @(negedge clk);
        check({tag, "_tx_pop"}, 32'(tx), 32'd1);
        check({tag, "_state_start"}, 32'(bus.state), 32'(ST_START));
        @(negedge clk);
        check({tag, "_tx_fall"}, 32'(tx), 32'd0);
    endtask

    // Entered at start-bit sample index 'skip'; leaves at the middle of the stop bit.
    task automatic expect_frame(input logic [7:0] b, input int skip, input string tag);
        repeat (HALF - skip) @(negedge clk);
        check({tag, "_start"}, 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (D) @(negedge clk);
            check($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(b[i]));
        end
        repeat (D) @(negedge clk);
        check({tag, "_stop"}, 32'(tx), 32'd1);
    endtask

    task automatic expect_next_start(input string tag);
        repeat (D - HALF) @(negedge clk);
        check({tag, "_no_gap"}, 32'(tx), 32'd0);
    endtask

    task automatic expect_idle_after_stop(input string tag);
        repeat (D - HALF) @(negedge clk);
        check({tag, "_tx_idle"}, 32'(tx), 32'd1);
        check({tag, "_busy_low"}, 32'(bus.tx_busy), 32'd0);
        check({tag, "_empty"}, 32'(bus.tx_empty), 32'd1);
    endtask

    initial begin
        logic stayed_high;
        int   len;

        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b0;

        // Reset held, then a long idle stretch
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(bus.tx_busy), 32'd0);
        check("rst_empty", 32'(bus.tx_empty), 32'd1);
        check("rst_full", 32'(bus.tx_full), 32'd0);
        check("rst_state", 32'(bus.state), 32'(ST_IDLE));
        rst_n = 1'b1;
        stayed_high = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        check("idle_1000_high", 32'(stayed_high), 32'd1);

        // Single 0x55 frame: every level is one bit time, busy clears after the stop bit
        push_expect_fall(8'h55, "f55");
        for (int k = 0; k < 9; k++) begin
            len = 0;
            while (tx === 1'((k % 2)) && len < 4 * D) begin
                @(negedge clk);
                len++;
            end
            check($sformatf("f55_level%0d_len", k), 32'(len), 32'(D));
        end
        repeat (HALF) @(negedge clk);
        check("f55_stop_level", 32'(tx), 32'd1);
        check("f55_busy_mid_stop", 32'(bus.tx_busy), 32'd1);
        repeat (D - HALF) @(negedge clk);
        check("f55_busy_after_stop", 32'(bus.tx_busy), 32'd0);
        check("f55_tx_after_stop", 32'(tx), 32'd1);

        // Lead frame in flight, four queued bytes fill the FIFO, a fifth is dropped
        push_expect_fall(8'h3C, "f3c");
        push(8'hA3);
        push(8'h00);
        push(8'hFF);
        check("q_full_after_3", 32'(bus.tx_full), 32'd0);
        push(8'h81);
        check("q_full_after_4", 32'(bus.tx_full), 32'd1);
        push(8'h7E);
        check("q_full_after_drop", 32'(bus.tx_full), 32'd1);
        expect_frame(8'h3C, 5, "q3c");
        expect_next_start("qa3");
        expect_frame(8'hA3, 0, "qa3");
        expect_next_start("q00");
        expect_frame(8'h00, 0, "q00");
        expect_next_start("qff");
        expect_frame(8'hFF, 0, "qff");
        expect_next_start("q81");
        expect_frame(8'h81, 0, "q81");
        expect_idle_after_stop("q_end");

        // Push lands on the same edge as the STOP->START pop while one byte is queued
        push_expect_fall(8'h12, "s12");
        push(8'h34);
        expect_frame(8'h12, 1, "s12");
        repeat (D - 2 - HALF) @(negedge clk);
        bus.tx_data  = 8'hC6;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        check("s_pop_push_empty", 32'(bus.tx_empty), 32'd0);
        check("s_pop_push_full", 32'(bus.tx_full), 32'd0);
        @(negedge clk);
        check("s34_no_gap", 32'(tx), 32'd0);
        push(8'h0D);
        push(8'hE1);
        check("s_count3_not_full", 32'(bus.tx_full), 32'd0);
        push(8'h2B);
        check("s_count4_full", 32'(bus.tx_full), 32'd1);
        expect_frame(8'h34, 3, "s34");
        expect_next_start("sc6");
        expect_frame(8'hC6, 0, "sc6");
        expect_next_start("s0d");
        expect_frame(8'h0D, 0, "s0d");
        expect_next_start("se1");
        expect_frame(8'hE1, 0, "se1");
        expect_next_start("s2b");
        expect_frame(8'h2B, 0, "s2b");
        expect_idle_after_stop("s_end");

        // Asynchronous reset during data bit 3 of 0xF0 with another byte queued
        push_expect_fall(8'hF0, "rf0");
        push(8'h99);
        repeat (HALF - 1 + 4 * D) @(negedge clk);
        check("r_bit3_low", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("r_async_tx", 32'(tx), 32'd1);
        check("r_async_empty", 32'(bus.tx_empty), 32'd1);
        check("r_async_full", 32'(bus.tx_full), 32'd0);
        check("r_async_busy", 32'(bus.tx_busy), 32'd0);
        check("r_async_state", 32'(bus.state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stayed_high = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        check("r_idle_after_release", 32'(stayed_high), 32'd1);
        push_expect_fall(8'h5A, "r5a");
        expect_frame(8'h5A, 0, "r5a");
        expect_idle_after_stop("r_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
